// File: rtl/uart_tx_drain.sv
// UART 8N1 transmitter that drains a first-word-fall-through TX FIFO, with frames sent back to back.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]            r_state;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  r_div_q;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  logic                  w_bit_end;
  logic                  w_load;
  logic [DIV_WIDTH-1:0]  w_div_eff;

  assign w_bit_end = (r_cnt == r_div_q - DIV_WIDTH'(1));
  // A new frame loads from IDLE or on the final STOP cycle, giving gapless back-to-back frames.
  assign w_load    = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end))
                     && !fifo_empty && !reset;
  assign w_div_eff = (div == '0) ? DIV_WIDTH'(1) : div;

  assign fifo_pop = w_load;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE);

  // r_tx is loaded with the level of the state being entered, so tx changes on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_div_q  <= DIV_WIDTH'(1);
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_load) begin
      r_shift  <= fifo_dout;
      r_div_q  <= w_div_eff;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_state  <= S_START;
      r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= ^fifo_dout;
`endif
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_cnt <= r_cnt + DIV_WIDTH'(1);
      end else begin
        r_cnt <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
          S_DATA: begin
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + BIT_W'(1);
              r_tx  <= r_shift[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
`endif
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
